// File: rtl/gpu_smem_pkg.sv
// Shared-memory bank controller package: geometry constants, FSM state
// encoding, the captured-request payload and a one-hot helper.
package gpu_smem_pkg;

  localparam int unsigned N_CORES  = 16;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WORDS    = 256;
  localparam int unsigned BANK_MSB = 11;
  localparam int unsigned BANK_LSB = 8;
  localparam int unsigned WORD_MSB = 7;

  localparam int unsigned ID_W   = $clog2(N_CORES);
  localparam int unsigned BANK_W = BANK_MSB - BANK_LSB + 1;
  localparam int unsigned WORD_W = WORD_MSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Request captured at grant; later changes on the core's buses are ignored.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              is_store;
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] data;
  } slot_t;

  function automatic logic [N_CORES-1:0] onehot(input logic [ID_W-1:0] id);
    return N_CORES'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker over 16 requesters.
// Ports: req    - raw request vector
//        last   - previously granted index (lowest priority next round)
//        mask   - requesters excluded from this pick
//        valid  - at least one unmasked request present
//        winner - first unmasked requester scanning upward from last+1
module rr_pick16
  import gpu_smem_pkg::*;
(
  input  logic [N_CORES-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic [N_CORES-1:0] mask,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  logic [N_CORES-1:0] cand;

  // Scan from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    cand   = req & ~mask;
    valid  = 1'b0;
    winner = '0;
    for (int k = N_CORES; k >= 1; k--) begin
      logic [ID_W-1:0] idx;
      idx = last + ID_W'(k);
      if (cand[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/smem_bank_rr_ctrl.sv
// Per-bank shared-memory controller: owns one 256x8 bank, arbitrates the
// cores' load/store requests round-robin and returns a tagged finish pulse.
// Optional statistics counters are built when SMEM_BANK_STATS_EN is defined.
// Ports: clk, reset (async, active-low)
//        bank_n        - static bank index of this instance
//        read/write    - per-core level requests, held until finish
//        addr_in       - core i address at [12i+11:12i]
//        data_in       - core i store data at [8i+7:8i]
//        data_out      - last load data (held across stores/idle)
//        data_core     - core id the finish pulse belongs to
//        finish        - one-hot, one-cycle completion pulse
//        busy          - high while in ACCESS or RESP
//        access_cnt    - (stats) completed accesses, saturating
//        conflict_cnt  - (stats) arbitration cycles with >=2 requesters
module smem_bank_rr_ctrl
  import gpu_smem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BANK_W-1:0]         bank_n,
  input  logic [N_CORES-1:0]        read,
  input  logic [N_CORES-1:0]        write,
  input  logic [N_CORES*ADDR_W-1:0] addr_in,
  input  logic [N_CORES*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic [ID_W-1:0]           data_core,
  output logic [N_CORES-1:0]        finish,
`ifdef SMEM_BANK_STATS_EN
  output logic [15:0]               access_cnt,
  output logic [15:0]               conflict_cnt,
`endif
  output logic                      busy
);

  state_e             state, state_nxt;
  slot_t              slot, slot_nxt;
  logic [ID_W-1:0]    last_grant, last_grant_nxt;
  logic [DATA_W-1:0]  data_out_nxt;
  logic [ID_W-1:0]    data_core_nxt;
  logic [N_CORES-1:0] finish_nxt;
  logic               busy_nxt;

  logic [N_CORES-1:0] req_c;
  logic [N_CORES-1:0] mask_c;
  logic               pick_valid_c;
  logic [ID_W-1:0]    pick_id_c;
  slot_t              win_slot_c;
  logic [DATA_W-1:0]  rd_data_c;

  logic [DATA_W-1:0]  mem [WORDS];

  // Qualify requests: any load/store whose bank field matches this instance.
  always_comb begin
    req_c = '0;
    for (int i = 0; i < N_CORES; i++) begin
      req_c[i] = (read[i] | write[i]) &&
                 (addr_in[i*ADDR_W+BANK_LSB +: BANK_W] == bank_n);
    end
  end

  // Re-arbitration in RESP excludes the core being finished this cycle.
  assign mask_c = (state == RESP) ? onehot(slot.id) : '0;

  rr_pick16 u_pick (
    .req    (req_c),
    .last   (last_grant),
    .mask   (mask_c),
    .valid  (pick_valid_c),
    .winner (pick_id_c)
  );

  // Winner's payload; a simultaneous read+write is a store.
  always_comb begin
    win_slot_c          = '0;
    win_slot_c.id       = pick_id_c;
    win_slot_c.is_store = write[pick_id_c];
    win_slot_c.word     = addr_in[32'(pick_id_c)*ADDR_W +: WORD_W];
    win_slot_c.data     = data_in[32'(pick_id_c)*DATA_W +: DATA_W];
  end

  assign rd_data_c = mem[slot.word];

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot;
    last_grant_nxt = last_grant;
    data_out_nxt   = data_out;
    data_core_nxt  = data_core;
    finish_nxt     = '0;
    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          slot_nxt  = win_slot_c;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!slot.is_store) data_out_nxt = rd_data_c;
        last_grant_nxt = slot.id;
        state_nxt      = RESP;
      end
      RESP: begin
        finish_nxt    = onehot(slot.id);
        data_core_nxt = slot.id;
        if (pick_valid_c) begin
          slot_nxt  = win_slot_c;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      slot       <= '0;
      last_grant <= ID_W'(N_CORES - 1);
      data_out   <= '0;
      data_core  <= '0;
      finish     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      last_grant <= last_grant_nxt;
      data_out   <= data_out_nxt;
      data_core  <= data_core_nxt;
      finish     <= finish_nxt;
      busy       <= busy_nxt;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == ACCESS && slot.is_store) mem[slot.word] <= slot.data;
  end

`ifdef SMEM_BANK_STATS_EN
  logic [N_CORES-1:0] cand_c;
  logic               multi_c;
  logic               arb_cycle_c;

  assign cand_c      = req_c & ~mask_c;
  assign multi_c     = |(cand_c & (cand_c - N_CORES'(1)));
  assign arb_cycle_c = (state == IDLE) || (state == RESP);

  // Saturating usage counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      access_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (state == RESP && access_cnt != 16'hFFFF)
        access_cnt <= access_cnt + 16'd1;
      if (arb_cycle_c && multi_c && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_smem_bank_rr_ctrl.sv
// Scoreboard bench for smem_bank_rr_ctrl: directed transactions push the
// expected (core, finish cycle, data_out) into a queue; a negedge monitor
// pops and compares on every finish pulse.
module tb_smem_bank_rr_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   bank_n;
  logic [15:0]  rd;
  logic [15:0]  wr;
  logic [191:0] addr_in;
  logic [127:0] data_in;
  logic [7:0]   data_out;
  logic [3:0]   data_core;
  logic [15:0]  finish;
  logic         busy;
`ifdef SMEM_BANK_STATS_EN
  logic [15:0]  access_cnt;
  logic [15:0]  conflict_cnt;
`endif

  smem_bank_rr_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .bank_n       (bank_n),
    .read         (rd),
    .write        (wr),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_core    (data_core),
    .finish       (finish),
`ifdef SMEM_BANK_STATS_EN
    .access_cnt   (access_cnt),
    .conflict_cnt (conflict_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         core;
    int         at_cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         need[16];
  logic [7:0] exp_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every finish pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && finish != 16'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got finish=%04h expected none (cycle %0d)", finish, cyc);
      end else begin
        e = sb.pop_front();
        chk("finish_vec", 32'(finish), 32'(16'(1) << e.core));
        chk("data_core", 32'(data_core), 32'(e.core));
        chk("finish_cycle", 32'(cyc), 32'(e.at_cyc));
        chk("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic set_req(input int core, input bit r, input bit w,
                         input logic [11:0] a, input logic [7:0] d);
    rd[core] = r;
    wr[core] = w;
    addr_in[12*core +: 12] = a;
    data_in[8*core +: 8]   = d;
  endtask

  task automatic expect_fin(input int core, input int at_cyc, input logic [7:0] d);
    exp_t e;
    e.core   = core;
    e.at_cyc = at_cyc;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic clr_need();
    foreach (need[i]) need[i] = 0;
  endtask

  // Hold requests until each core has seen its required number of finishes.
  task automatic wait_done();
    int  got[16];
    bit  done;
    foreach (got[i]) got[i] = 0;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (finish[i]) got[i]++;
        if (got[i] >= need[i]) begin
          rd[i] = 1'b0;
          wr[i] = 1'b0;
        end else begin
          done = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got incomplete service expected all finishes (cycle %0d)", cyc);
      rd = '0;
      wr = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    rd       = '0;
    wr       = '0;
    exp_dout = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int c;
    reset    = 1'b0;
    rd       = '0;
    wr       = '0;
    addr_in  = '0;
    data_in  = '0;
    bank_n   = 4'd5;
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_finish", 32'(finish), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_core", 32'(data_core), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Core 3 store 0xA5 to 0x512 then load it back.
    clr_need(); need[3] = 1;
    c = cyc;
    set_req(3, 1'b0, 1'b1, 12'h512, 8'hA5);
    expect_fin(3, c + 3, exp_dout);
    wait_done();
    c = cyc;
    set_req(3, 1'b1, 1'b0, 12'h512, 8'h00);
    exp_dout = 8'hA5;
    expect_fin(3, c + 3, exp_dout);
    wait_done();

    // All 16 cores store to bank 2, then all 16 load back after a reset.
    do_reset();
    bank_n = 4'd2;
    clr_need();
    c = cyc;
    for (int i = 0; i < 16; i++) begin
      set_req(i, 1'b0, 1'b1, {4'h2, 8'(i)}, 8'(8'h10 + i));
      expect_fin(i, c + 3 + 2*i, exp_dout);
      need[i] = 1;
    end
    wait_done();
    do_reset();
    c = cyc;
    for (int i = 0; i < 16; i++) begin
      set_req(i, 1'b1, 1'b0, {4'h2, 8'(i)}, 8'h00);
      expect_fin(i, c + 3 + 2*i, 8'(8'h10 + i));
      need[i] = 1;
    end
    exp_dout = 8'h1F;
    wait_done();

    // Persistent core 7 against core 9: service 7, 9, 7.
    do_reset();
    clr_need(); need[7] = 2; need[9] = 1;
    c = cyc;
    set_req(7, 1'b1, 1'b0, 12'h205, 8'h00);
    set_req(9, 1'b1, 1'b0, 12'h209, 8'h00);
    expect_fin(7, c + 3, 8'h15);
    expect_fin(9, c + 5, 8'h19);
    expect_fin(7, c + 7, 8'h15);
    exp_dout = 8'h15;
    wait_done();

    // Request to another bank is ignored.
    bank_n = 4'd4;
    set_req(1, 1'b1, 1'b0, 12'h3FF, 8'h00);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("filter_busy", 32'(busy), 32'h0);
    end
    rd[1] = 1'b0;
    @(negedge clk);

    // Read+write together is a store; a later load sees it.
    clr_need(); need[12] = 1;
    c = cyc;
    set_req(12, 1'b1, 1'b1, 12'h4C0, 8'h3C);
    expect_fin(12, c + 3, exp_dout);
    wait_done();
    c = cyc;
    set_req(12, 1'b1, 1'b0, 12'h4C0, 8'h00);
    exp_dout = 8'h3C;
    expect_fin(12, c + 3, exp_dout);
    wait_done();

    // Reset during ACCESS aborts; afterwards core 0 beats core 15.
    set_req(5, 1'b1, 1'b0, 12'h4C0, 8'h00);
    @(negedge clk);
    chk("access_busy", 32'(busy), 32'h1);
    reset    = 1'b0;
    rd       = '0;
    wr       = '0;
    exp_dout = 8'h00;
    @(negedge clk);
    chk("abort_finish", 32'(finish), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_data_out", 32'(data_out), 32'h0);
    chk("abort_data_core", 32'(data_core), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    clr_need(); need[0] = 1; need[15] = 1;
    c = cyc;
    set_req(0, 1'b1, 1'b0, 12'h4C0, 8'h00);
    set_req(15, 1'b1, 1'b0, 12'h4C0, 8'h00);
    expect_fin(0, c + 3, 8'h3C);
    expect_fin(15, c + 5, 8'h3C);
    exp_dout = 8'h3C;
    wait_done();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
